// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int MULT_LAT_DEF = 17;
  localparam int OP_W         = 16;
  localparam int PROD_W       = 32;

  // Keeps index ports at least one bit wide when only one requester exists.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter (slave).
interface mult_arbiter_if
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [OP_W*N_REQ-1:0] req_opa;
  logic [OP_W*N_REQ-1:0] req_opb;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [PROD_W-1:0]     rsp_data;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid, req_opa, req_opb, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_opa, req_opb, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mult_arbiter_bit16_mult.sv
// Shift-add 16x16 unsigned multiplier: bit 0 is folded in at load, the other
// 15 bits take one cycle each, so mult_out is final 16 cycles after op_ld.
module bit16_mult
  import mult_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              arst_n,
  input  logic              op_ld,
  input  logic [OP_W-1:0]   opa,
  input  logic [OP_W-1:0]   opb,
  output logic [PROD_W-1:0] mult_out
);
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] mcand_q;
  logic [OP_W-1:0]   mplier_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (srst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (op_ld) begin
      acc_q    <= opb[0] ? PROD_W'(opa) : '0;
      mcand_q  <= PROD_W'(opa) << 1;
      mplier_q <= opb >> 1;
    end else begin
      // Once the multiplier bits are exhausted no further adds happen.
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign mult_out = acc_q;
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among N_REQ requesters;
// one operation in flight, response held until rsp_ready.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic           clk,
  input  logic           srst,
  mult_arbiter_if.slave  bus
);
  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 2);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [OP_W-1:0]    opa_q;
  logic [OP_W-1:0]    opb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   req_ready_q;
  logic [PROD_W-1:0]  rsp_data_q;
  logic [PROD_W-1:0]  mult_out;
  logic               mult_ld;
  logic [ID_W-1:0]    pick;

  logic [OP_W-1:0] opa_arr [N_REQ];
  logic [OP_W-1:0] opb_arr [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign opa_arr[gi] = bus.req_opa[gi*OP_W +: OP_W];
    assign opb_arr[gi] = bus.req_opb[gi*OP_W +: OP_W];
  end

  // First valid requester at or after the pointer, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] res;
    logic            found;
    int              idx;
    res   = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(p) + off) % N_REQ;
      if (!found && v[idx]) begin
        res   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign pick = rr_pick(bus.req_valid, ptr_q);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            id_q        <= pick;
            opa_q       <= opa_arr[pick];
            opb_q       <= opb_arr[pick];
            req_ready_q <= N_REQ'(1) << pick;
            ptr_q       <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_q   <= '0;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          // Capture on the last CALC cycle so rsp_valid lands MULT_LAT after op_ld.
          if (cnt_q == CNT_LAST) begin
            rsp_data_q <= mult_out;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mult_ld = (state_q == ST_LOAD);

  bit16_mult u_mult (
    .clk      (clk),
    .srst     (srst),
    .arst_n   (1'b1),
    .op_ld    (mult_ld),
    .opa      (opa_q),
    .opb      (opb_q),
    .mult_out (mult_out)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized checks of grant order, latency, backpressure,
// reset behaviour and product values for mult_arbiter.
`timescale 1ns/1ps
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W_READY = 0;
  localparam int W_LD    = 1;
  localparam int W_RSP   = 2;

  logic clk = 1'b0;
  logic srst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(N)) bus ();

  mult_arbiter #(.N_REQ(N), .MULT_LAT(17)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]       = v;
    bus.req_opa[i*16 +: 16] = a;
    bus.req_opb[i*16 +: 16] = b;
  endtask

  task automatic wait_for(input int which, input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      case (which)
        W_READY: ok = (bus.req_ready != '0);
        W_LD:    ok = dut.mult_ld;
        default: ok = bus.rsp_valid;
      endcase
    end
  endtask

  task automatic run_op(input int who, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    int n;
    bit ok;
    set_req(who, 1'b1, a, b);
    wait_for(W_READY, 50, n, ok);
    check("grant_seen", 32'(ok), 1);
    check("grant_onehot", 32'(bus.req_ready), 32'(1 << who));
    set_req(who, 1'b0, a, b);
    if (!dut.mult_ld) begin
      wait_for(W_LD, 10, n, ok);
      check("op_ld_seen", 32'(ok), 1);
    end
    wait_for(W_RSP, 40, n, ok);
    check("latency", 32'(n), 17);
    check("rsp_data", bus.rsp_data, exp);
    check("rsp_id", 32'(bus.rsp_id), 32'(who));
    $display("txn req%0d a=0x%04h b=0x%04h -> 0x%08h id=%0d", who, a, b, bus.rsp_data, bus.rsp_id);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", 32'(bus.rsp_valid), 0);
    bus.rsp_ready = 1'b0;
  endtask

  logic [15:0] rr_a [N] = '{16'h0002, 16'h0003, 16'h0010, 16'h0100};
  logic [15:0] rr_b [N] = '{16'h0007, 16'h000B, 16'h0011, 16'h0020};
  logic [31:0] rr_p [N] = '{32'h0000000E, 32'h00000021, 32'h00000110, 32'h00002000};

  initial begin
    int n;
    bit ok;
    bit stable, seen;
    logic [31:0] d0;
    logic [1:0]  id0;
    logic [33:0] sb_q[$];
    int grants, resps, cyc;
    bit checked_cur;
    logic [15:0] ra, rb;

    srst = 1'b1;
    bus.req_valid = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    srst = 1'b0;
    @(negedge clk);

    run_op(0, 16'd3, 16'd5, 32'h0000000F);
    run_op(2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op(3, 16'h1234, 16'h0000, 32'h00000000);
    run_op(1, 16'h0000, 16'h0000, 32'h00000000);

    // Backpressure with another request pending; it is granted only after RESP completes.
    set_req(1, 1'b1, 16'h00AB, 16'h0CD0);
    wait_for(W_READY, 50, n, ok);
    check("bp_grant", 32'(bus.req_ready), 32'h2);
    set_req(1, 1'b0, 16'h00AB, 16'h0CD0);
    wait_for(W_RSP, 40, n, ok);
    check("bp_rsp_seen", 32'(ok), 1);
    check("bp_rsp_data", bus.rsp_data, 32'h00088EF0);
    set_req(3, 1'b1, 16'h0011, 16'h0022);
    d0 = bus.rsp_data;
    id0 = bus.rsp_id;
    stable = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_id !== id0) stable = 1'b0;
      if (bus.req_ready != '0) seen = 1'b1;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_no_grant", 32'(seen), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_done", 32'(bus.rsp_valid), 0);
    check("late_req_not_yet", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("late_req_grant", 32'(bus.req_ready), 32'h8);
    set_req(3, 1'b0, 16'h0011, 16'h0022);
    wait_for(W_RSP, 40, n, ok);
    check("late_rsp_data", bus.rsp_data, 32'h00000242);
    check("late_rsp_id", 32'(bus.rsp_id), 3);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // All requesters held through reset: grant order from pointer 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rr_a[i], rr_b[i]);
    srst = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_hold_grant", 32'(bus.req_ready), 32'h1);
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        wait_for(W_READY, 50, n, ok);
        check("rr_grant_seen", 32'(ok), 1);
      end
      check("rr_order", 32'(bus.req_ready), 32'(1 << (g % N)));
      wait_for(W_RSP, 40, n, ok);
      check("rr_rsp_id", 32'(bus.rsp_id), 32'(g % N));
      check("rr_rsp_data", bus.rsp_data, rr_p[g % N]);
      $display("txn rr grant %0d -> req%0d data=0x%08h", g, bus.rsp_id, bus.rsp_data);
    end
    bus.req_valid = '0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // A lone requester is served back to back.
    set_req(2, 1'b1, 16'h0100, 16'h0003);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(W_READY, 50, n, ok);
      check("b2b_grant", 32'(bus.req_ready), 32'h4);
      wait_for(W_RSP, 40, n, ok);
      check("b2b_data", bus.rsp_data, 32'h00000300);
      $display("txn b2b %0d req2 data=0x%08h", k, bus.rsp_data);
    end
    set_req(2, 1'b0, 16'h0100, 16'h0003);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of CALC aborts the operation silently.
    set_req(0, 1'b1, 16'h0123, 16'h0456);
    wait_for(W_READY, 50, n, ok);
    set_req(0, 1'b0, 16'h0123, 16'h0456);
    if (!dut.mult_ld) wait_for(W_LD, 10, n, ok);
    repeat (8) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    check("abort_rsp_data", bus.rsp_data, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 0);
    run_op(0, 16'd7, 16'd9, 32'd63);

    // Random soak against a scoreboard of accepted requests.
    grants = 0;
    resps = 0;
    cyc = 0;
    checked_cur = 1'b0;
    while (resps < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready != '0) begin
        check("soak_onehot", 32'($countones(bus.req_ready)), 1);
        for (int i = 0; i < N; i++) begin
          if (bus.req_ready[i]) begin
            sb_q.push_back({2'(i), 32'(bus.req_opa[i*16 +: 16]) * 32'(bus.req_opb[i*16 +: 16])});
            grants++;
          end
        end
      end
      if (bus.rsp_valid && !checked_cur) begin
        check("soak_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          check("soak_id", 32'(bus.rsp_id), 32'(sb_q[0][33:32]));
          check("soak_data", bus.rsp_data, sb_q[0][31:0]);
        end
        checked_cur = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: ra = 16'h0000;
          1: ra = 16'hFFFF;
          default: ra = 16'($urandom);
        endcase
        rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        set_req(i, ($urandom_range(0, 3) != 0), ra, rb);
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        resps++;
        checked_cur = 1'b0;
      end
    end
    bus.req_valid = '0;
    check("soak_resp_count", 32'(resps), 1000);
    check("soak_balance", 32'(grants), 32'(resps));
    check("soak_queue_empty", 32'(sb_q.size()), 0);
    $display("txn soak grants=%0d responses=%0d cycles=%0d", grants, resps, cyc);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("soak_idle", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL expose parameter N_REQ, default 4, as the number of requesters sharing the multiplier.
REQ-002 The block SHALL expose parameter MULT_LAT, default 17, as the number of cycles from the op_ld cycle to the product being valid on mult_out.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL provide port srst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL provide port req_valid, input, N_REQ, per-requester operation request.
REQ-006 The block SHALL provide port req_opa, input, 16*N_REQ, unsigned multiplicand, 16 bits per requester; requester i uses slice [16i+15:16i].
REQ-007 The block SHALL provide port req_opb, input, 16*N_REQ, unsigned multiplier, 16 bits per requester, packed as for req_opa.
REQ-008 The block SHALL provide port req_ready, output, N_REQ, one-hot accept pulse to the granted requester.
REQ-009 The block SHALL provide port rsp_valid, output, 1, product available.
REQ-010 The block SHALL provide port rsp_id, output, clog2(N_REQ), index of the requester owning the response.
REQ-011 The block SHALL provide port rsp_data, output, 32, unsigned product.
REQ-012 The block SHALL provide port rsp_ready, input, 1, response consumed.
REQ-013 The block SHALL provide port busy, output, 1, high in every state except IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOAD, CALC, RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL grant the requester selected round-robin from the pointer position, pulse that requester's req_ready for one cycle, latch its index and operands, and go to LOAD; requests are accepted only in IDLE.
REQ-016 In LOAD, the block SHALL drive multiplier op_ld high for exactly one cycle with the latched operands, then go to CALC.
REQ-017 In CALC, a cycle counter SHALL run for MULT_LAT-1 cycles (16); then the block SHALL capture mult_out into rsp_data and go to RESP.
REQ-018 rsp_valid SHALL therefore rise exactly MULT_LAT cycles after the op_ld cycle.
REQ-019 In RESP, rsp_valid, rsp_id and rsp_data SHALL be held stable until a cycle with rsp_ready high; on that cycle the block SHALL return to IDLE.
REQ-020 Under backpressure, new requests SHALL wait; req_ready SHALL be low outside IDLE.
REQ-021 On grant, the round-robin pointer SHALL advance to granted index+1, wrapping N_REQ-1 to 0.
REQ-022 A requester that has just been served SHALL have lowest priority on the next grant.
REQ-023 With a single requester continuously valid, back-to-back operations SHALL occur with no starvation or lockout.
REQ-024 The product SHALL be the full unsigned 32-bit product; no truncation or saturation.
REQ-025 Zero operands SHALL produce 0.
REQ-026 An operand value of 0xFFFF SHALL produce the exact 32-bit result.
REQ-027 req_valid SHALL be sampled only in IDLE; deassertion in other states SHALL have no effect.
REQ-028 rsp_ready asserted outside RESP SHALL be ignored.
REQ-029 If req_valid goes high in the same cycle that RESP completes, it SHALL not be granted until the following IDLE cycle.

Reset
REQ-030 srst high SHALL, at the next clock edge, force state IDLE and pointer 0.
REQ-031 srst high SHALL, at the next clock edge, force req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0 and the counter to 0.
REQ-032 srst SHALL be forwarded to the multiplier's srst, so a reset mid-CALC or mid-RESP aborts the operation with no response emitted.
REQ-033 The multiplier's asynchronous reset input SHALL be tied inactive (1'b1).
REQ-034 A request held through reset SHALL be granted in the first IDLE cycle after srst deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (2 bits), the MULT_LAT default and the operand/product width constants (16, 32).
REQ-036 Exactly one sub-module SHALL be instantiated: bit16_mult (the shift-add multiplier), named u_mult.
REQ-037 The arbiter's round-robin select SHALL be a combinational function within mult_arbiter, not a separate module.

Verification
REQ-038 Single op: req0 with opa=3, opb=5, rsp_ready=1 -> req_ready[0] pulses once; rsp_valid=1 exactly 17 cycles after op_ld with rsp_data=0x0000000F and rsp_id=0.
REQ-039 Extreme values: opa=0xFFFF, opb=0xFFFF -> rsp_data=0xFFFE0001; opa=0x1234, opb=0 -> rsp_data=0.
REQ-040 Round-robin: all 4 requesters valid continuously from reset -> grant order 0,1,2,3,0 with no requester served twice before the others.
REQ-041 Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay stable, no req_ready pulses; completion 1 cycle after rsp_ready rises.
REQ-042 Reset mid-op: srst pulsed 8 cycles into CALC -> next cycle busy=0 and rsp_valid=0; a fresh op opa=7, opb=9 -> rsp_data=63.
REQ-043 Random soak: 1000 random operand/valid/rsp_ready patterns -> every product matches the reference model, and every accepted request gets exactly one response.
